// File: rtl/usb_wb_bridge_pkg.sv
// Shared types and defaults for the Wishbone-to-register-bus bridge.
package usb_wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int          DEF_TIMEOUT  = 255;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/usb_wb_bridge_if.sv
// Wishbone slave port plus register-bus master port of the bridge, bundled together.
interface usb_wb_bridge_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [10:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;

    logic        reg_cs;
    logic        reg_wr;
    logic [8:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    // The bridge itself
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    // The environment: Wishbone master and register-bus target
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );

endinterface

// File: rtl/usb_wb_bridge.sv
// Single-outstanding Wishbone slave that forwards each access to a simple register bus,
// with a wait-cycle limit that turns a missing reg_ack into a Wishbone error.
module usb_wb_bridge
    import usb_wb_bridge_pkg::*;
#(
    parameter int          TIMEOUT  = DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic            app_clk,
    input  logic            usb_rstn,
    usb_wb_bridge_if.slave  bus,
    output logic            tmo_flag_o
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        alive_q, alive_d;
    logic        reg_cs_q, reg_cs_d;
    logic        reg_wr_q, reg_wr_d;
    logic [8:0]  reg_addr_q, reg_addr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic [3:0]  reg_be_q, reg_be_d;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic        master_here;

    // Responses are only reported if the master kept cyc high for the whole access.
    assign master_here = alive_q & bus.wbs_cyc_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alive_d     = alive_q;
        reg_cs_d    = reg_cs_q;
        reg_wr_d    = reg_wr_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_be_d    = reg_be_q;
        dat_d       = dat_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        tmo_d       = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                    reg_wr_d    = bus.wbs_we_i;
                    reg_addr_d  = bus.wbs_adr_i[10:2];
                    reg_wdata_d = bus.wbs_dat_i;
                    reg_be_d    = bus.wbs_sel_i;
                    reg_cs_d    = 1'b1;
                    cnt_d       = '0;
                    alive_d     = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d   = cnt_q + CW'(1);
                alive_d = master_here;
                // reg_ack is checked first so a late ack on the last wait cycle still wins.
                if (bus.reg_ack) begin
                    reg_cs_d = 1'b0;
                    dat_d    = reg_wr_q ? 32'h0 : bus.reg_rdata;
                    ack_d    = master_here;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    reg_cs_d = 1'b0;
                    dat_d    = ERR_DATA;
                    err_d    = master_here;
                    tmo_d    = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge app_clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alive_q     <= 1'b0;
            reg_cs_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_be_q    <= '0;
            dat_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alive_q     <= alive_d;
            reg_cs_q    <= reg_cs_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_be_q    <= reg_be_d;
            dat_q       <= dat_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.reg_cs    = reg_cs_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_be    = reg_be_q;
    assign bus.wbs_dat_o = dat_q;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_err_o = err_q;
    assign tmo_flag_o    = tmo_q;

endmodule

// File: tb/tb_usb_wb_bridge.sv
// Scoreboard bench for usb_wb_bridge: stimulus pushes expected register-bus requests and
// Wishbone responses; two monitors pop and compare whenever the DUT presents them.
module tb_usb_wb_bridge;
    import usb_wb_bridge_pkg::*;

    localparam int          TMO  = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          len;
    } req_t;

    logic app_clk  = 1'b0;
    logic usb_rstn = 1'b0;
    logic tmo_flag_o;

    resp_t resp_q[$];
    req_t  req_q[$];
    int    total = 0;
    int    bad   = 0;

    usb_wb_bridge_if bus();

    usb_wb_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
        .app_clk   (app_clk),
        .usb_rstn  (usb_rstn),
        .bus       (bus),
        .tmo_flag_o(tmo_flag_o)
    );

    always #5 app_clk = ~app_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_reg_cs"},    32'(bus.reg_cs),    32'h0);
        checkOutput({tag, "_reg_wr"},    32'(bus.reg_wr),    32'h0);
        checkOutput({tag, "_reg_addr"},  32'(bus.reg_addr),  32'h0);
        checkOutput({tag, "_reg_wdata"}, bus.reg_wdata,      32'h0);
        checkOutput({tag, "_reg_be"},    32'(bus.reg_be),    32'h0);
        checkOutput({tag, "_wbs_dat"},   bus.wbs_dat_o,      32'h0);
        checkOutput({tag, "_wbs_ack"},   32'(bus.wbs_ack_o), 32'h0);
        checkOutput({tag, "_wbs_err"},   32'(bus.wbs_err_o), 32'h0);
        checkOutput({tag, "_tmo_flag"},  32'(tmo_flag_o),    32'h0);
    endtask

    // One Wishbone access with a scripted register-bus target.
    // ack_after: reg_ack sampled on edge N+ack_after (0 = never); drop_after/rst_after: 0 = off.
    task automatic applyStimulus(input logic we, input logic [10:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int ack_after, input logic [31:0] rdata,
                                 input int drop_after, input int rst_after, input logic hold);
        req_t  rq;
        resp_t rs;
        logic  expect_resp;
        logic  acked;
        logic  done;
        acked       = (ack_after > 0) && (ack_after <= TMO);
        expect_resp = (drop_after == 0) && (rst_after == 0);
        @(negedge app_clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        bus.reg_ack   = 1'b0;
        rq.wr    = we;
        rq.addr  = adr[10:2];
        rq.wdata = dat;
        rq.be    = sel;
        rq.len   = (rst_after > 0) ? 0 : (acked ? ack_after : TMO);
        req_q.push_back(rq);
        if (expect_resp) begin
            rs.err  = !acked;
            rs.data = !acked ? ERRD : (we ? 32'h0 : rdata);
            resp_q.push_back(rs);
        end
        @(posedge app_clk);
        done = 1'b0;
        for (int i = 1; i <= TMO + 6 && !done; i++) begin
            @(negedge app_clk);
            if (expect_resp && (bus.wbs_ack_o || bus.wbs_err_o)) begin
                done = 1'b1;
                if (!hold) begin
                    bus.wbs_cyc_i = 1'b0;
                    bus.wbs_stb_i = 1'b0;
                end
            end
            if (i == drop_after) begin
                bus.wbs_cyc_i = 1'b0;
                bus.wbs_stb_i = 1'b0;
            end
            if (i == rst_after) begin
                usb_rstn      = 1'b0;
                bus.wbs_cyc_i = 1'b0;
                bus.wbs_stb_i = 1'b0;
                #1;
                checkZeros("mid_req_reset");
                @(negedge app_clk);
                usb_rstn = 1'b1;
            end
            bus.reg_ack   = (i == ack_after) && !done;
            bus.reg_rdata = rdata;
        end
        bus.reg_ack = 1'b0;
        if (expect_resp && !done) checkOutput("resp_wait_expired", 32'h1, 32'h0);
    endtask

    // Wishbone response monitor.
    initial begin : mon_resp
        resp_t r;
        logic  prev;
        prev = 1'b0;
        forever begin
            @(negedge app_clk);
            if (usb_rstn && (bus.wbs_ack_o || bus.wbs_err_o)) begin
                checkOutput("ack_err_exclusive", 32'(bus.wbs_ack_o & bus.wbs_err_o), 32'h0);
                checkOutput("resp_spacing", 32'(prev), 32'h0);
                if (resp_q.size() == 0) begin
                    checkOutput("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    r = resp_q.pop_front();
                    checkOutput("resp_err", 32'(bus.wbs_err_o), 32'(r.err));
                    checkOutput("resp_ack", 32'(bus.wbs_ack_o), 32'(!r.err));
                    checkOutput("resp_data", bus.wbs_dat_o, r.data);
                end
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
    end

    // Register-bus request monitor: fields held for every cs cycle, cs length on its fall.
    initial begin : mon_reg
        req_t cur;
        int   cnt;
        cnt       = 0;
        cur.wr    = 1'b0;
        cur.addr  = '0;
        cur.wdata = '0;
        cur.be    = '0;
        cur.len   = 0;
        forever begin
            @(negedge app_clk);
            if (!usb_rstn) begin
                cnt = 0;
            end else if (bus.reg_cs) begin
                if (cnt == 0) begin
                    if (req_q.size() == 0) checkOutput("unexpected_reg_cs", 32'h1, 32'h0);
                    else cur = req_q.pop_front();
                end
                checkOutput("reg_wr",    32'(bus.reg_wr),   32'(cur.wr));
                checkOutput("reg_addr",  32'(bus.reg_addr), 32'(cur.addr));
                checkOutput("reg_wdata", bus.reg_wdata,     cur.wdata);
                checkOutput("reg_be",    32'(bus.reg_be),   32'(cur.be));
                cnt++;
            end else if (cnt > 0) begin
                if (cur.len != 0) checkOutput("reg_cs_cycles", 32'(cnt), 32'(cur.len));
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_sel_i = '0;
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = '0;
        usb_rstn      = 1'b0;
        repeat (2) @(negedge app_clk);
        checkZeros("reset");
        usb_rstn = 1'b1;

        // Basic read, write, zero byte-enable write, minimum latency read
        applyStimulus(1'b0, 11'h088, 32'h0,         4'hF, 3, 32'h1234_5678, 0, 0, 1'b0);
        applyStimulus(1'b1, 11'h084, 32'hA5A5_0001, 4'h3, 2, 32'hFFFF_FFFF, 0, 0, 1'b0);
        applyStimulus(1'b1, 11'h7FC, 32'h0BAD_F00D, 4'h0, 1, 32'h5555_AAAA, 0, 0, 1'b0);
        applyStimulus(1'b0, 11'h003, 32'h0,         4'hF, 1, 32'h0000_0001, 0, 0, 1'b0);

        // Ack on the very last wait cycle beats the timeout
        applyStimulus(1'b0, 11'h010, 32'h0, 4'hF, TMO, 32'hCAFE_0008, 0, 0, 1'b0);
        checkOutput("tmo_flag_after_boundary", 32'(tmo_flag_o), 32'h0);

        // No ack at all: error response
        applyStimulus(1'b0, 11'h020, 32'h0, 4'hF, 0, 32'h0, 0, 0, 1'b0);
        checkOutput("tmo_flag_after_timeout", 32'(tmo_flag_o), 32'h1);

        // Master abandons the cycle; reg access completes silently
        applyStimulus(1'b0, 11'h030, 32'h0, 4'hF, 3, 32'h7777_7777, 1, 0, 1'b0);
        checkOutput("tmo_flag_sticky", 32'(tmo_flag_o), 32'h1);

        // Stray reg_ack while idle must do nothing
        @(negedge app_clk);
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 32'h9999_9999;
        @(negedge app_clk);
        bus.reg_ack = 1'b0;
        repeat (2) @(negedge app_clk);

        // Back-to-back reads with stb held between them
        applyStimulus(1'b0, 11'h100, 32'h0, 4'hF, 1, 32'h0000_0100, 0, 0, 1'b1);
        applyStimulus(1'b0, 11'h104, 32'h0, 4'hF, 2, 32'h0000_0104, 0, 0, 1'b1);
        applyStimulus(1'b0, 11'h108, 32'h0, 4'hF, 1, 32'h0000_0108, 0, 0, 1'b1);
        applyStimulus(1'b0, 11'h10C, 32'h0, 4'hF, 3, 32'h0000_010C, 0, 0, 1'b0);

        // Reset in the middle of a request, then normal traffic again
        applyStimulus(1'b0, 11'h040, 32'h0, 4'hF, 0, 32'h0, 0, 3, 1'b0);
        applyStimulus(1'b1, 11'h044, 32'h1357_9BDF, 4'hC, 2, 32'h2468_ACE0, 0, 0, 1'b0);

        repeat (4) @(negedge app_clk);
        checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'h0);
        checkOutput("req_queue_drained",  32'(req_q.size()),  32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_wb_bridge.md
USB_WB_BRIDGE -- requirements
Module: usb_wb_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, is the reg-bus wait limit in app_clk cycles (legal range 2..65535).
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF, is the read data returned on timeout.
REQ-003 app_clk  in  1  single clock for the whole block.
REQ-004 usb_rstn  in  1  reset, asynchronous and active-low.
REQ-005 wbs_cyc_i  in  1  Wishbone cycle valid.
REQ-006 wbs_stb_i  in  1  Wishbone strobe.
REQ-007 wbs_we_i  in  1  write (1) / read (0).
REQ-008 wbs_adr_i  in  11  byte address; bits [1:0] are ignored.
REQ-009 wbs_dat_i  in  32  write data.
REQ-010 wbs_sel_i  in  4  byte enables.
REQ-011 wbs_dat_o  out  32  read data.
REQ-012 wbs_ack_o  out  1  transfer done.
REQ-013 wbs_err_o  out  1  transfer timed out.
REQ-014 reg_cs, reg_wr  out  1 each  reg-bus request and write qualifier.
REQ-015 reg_addr  out  9  word address, equal to wbs_adr_i[10:2].
REQ-016 reg_wdata  out  32 and reg_be  out  4  captured write data and byte enables.
REQ-017 reg_rdata  in  32 and reg_ack  in  1  reg-bus response.
REQ-018 tmo_flag_o  out  1  sticky flag indicating at least one timeout has occurred.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, REQ and RESP.
REQ-020 In IDLE, when wbs_cyc_i=1 and wbs_stb_i=1 on edge N, the block SHALL register we, adr[10:2], dat and sel, and enter REQ.
- reg_cs=1 from cycle N+1.
REQ-021 reg_wr, reg_addr, reg_wdata and reg_be SHALL be registered outputs, held stable for the whole of REQ, and SHALL not change in IDLE.
REQ-022 In REQ, a wait counter SHALL clear on entry and increment by 1 per cycle.
REQ-023 In REQ, reg_ack=1 on edge K SHALL cause the following, then entry to RESP:
- reg_cs=0 from K+1;
- wbs_ack_o=1 for exactly the cycle K+1;
- wbs_dat_o = reg_rdata sampled at K for a read, or 32'h0 for a write.
REQ-024 In REQ, when the counter reaches TIMEOUT-1 with reg_ack=0, the block SHALL then enter RESP:
- reg_cs=0 next cycle;
- wbs_err_o=1 for one cycle;
- wbs_dat_o=ERR_DATA;
- tmo_flag_o set.
REQ-025 If reg_ack and the timeout condition coincide in the same cycle, ack SHALL win and no error SHALL be reported.
REQ-026 RESP SHALL last one cycle and return to IDLE; any strobe seen in RESP SHALL be ignored, so back-to-back requests are spaced by at least one idle cycle.
REQ-027 If wbs_cyc_i drops during REQ, the reg-bus access SHALL still complete (or time out), but wbs_ack_o and wbs_err_o SHALL be suppressed.
REQ-028 reg_ack received in IDLE or RESP SHALL be ignored.
REQ-029 wbs_ack_o and wbs_err_o SHALL never be high in the same cycle.
REQ-030 wbs_sel_i=4'h0 SHALL still be forwarded as an ordinary access.
REQ-031 Minimum latency SHALL be strobe at N, reg_ack at N+1, wbs_ack_o at N+2.
REQ-032 tmo_flag_o SHALL clear only on reset.

Reset
REQ-033 On usb_rstn=0 the block SHALL asynchronously force:
- state to IDLE and the counter to 0;
- reg_cs, reg_wr, wbs_ack_o, wbs_err_o and tmo_flag_o to 0;
- reg_addr, reg_wdata, reg_be and wbs_dat_o to 0.
REQ-034 Reset asserted mid-REQ SHALL abandon the access, with no ack or err after release.
REQ-035 After usb_rstn deasserts, the first strobe SHALL be accepted on the next app_clk edge.

Structure
REQ-036 A package usb_wb_bridge_pkg SHALL hold the FSM state enum, the default TIMEOUT value and the default ERR_DATA value.
REQ-037 The counter width SHALL be $clog2(TIMEOUT+1).
REQ-038 The block SHALL contain no sub-module; it is a single FSM with a counter.

Verification
REQ-039 Read: adr=11'h088, reg_ack after 3 cycles with rdata=32'h1234_5678 -> reg_addr=9'h022, reg_cs high 3 cycles, wbs_ack_o one cycle, wbs_dat_o=32'h1234_5678.
REQ-040 Write: adr=11'h084, dat=32'hA5A5_0001, sel=4'h3 -> reg_wr=1, reg_wdata=32'hA5A5_0001, reg_be=4'h3, wbs_ack_o one cycle, wbs_dat_o=0.
REQ-041 Timeout: TIMEOUT=8, reg_ack never asserted -> reg_cs high 8 cycles, then wbs_err_o=1, wbs_dat_o=32'hDEAD_BEEF, tmo_flag_o=1, no wbs_ack_o.
REQ-042 Boundary: reg_ack exactly on cycle TIMEOUT-1 -> wbs_ack_o=1, wbs_err_o=0, tmo_flag_o unchanged.
REQ-043 Abort/reset:
- cyc dropped after 1 REQ cycle, then reg_ack -> no wbs_ack_o;
- usb_rstn pulsed mid-REQ -> all outputs 0 and no stale ack after release.
REQ-044 Back-to-back: 4 reads with stb held high -> 4 acks, each separated by a RESP cycle, and addresses forwarded in order.
